// File: rtl/rs_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// rs_pkg: shared types, widths and CDB helpers for the reservation station
// Revision: 1.0
// ------------------------------------------------------------------
package rs_pkg;

  localparam int TAG_W   = 8;
  localparam int DATA_W  = 32;
  localparam int NUM_CDB = 3;
  localparam logic [TAG_W-1:0] TAG_NONE = 8'd0;

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic [TAG_W-1:0]  q;
    logic              r;
  } rs_opnd_t;

  // Opcode lives beside the entry because its width is a module parameter.
  typedef struct packed {
    logic     busy;
    rs_opnd_t o1;
    rs_opnd_t o2;
  } rs_entry_t;

  function automatic logic tag_match(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    return (a == b) && (b != TAG_NONE);
  endfunction

  function automatic logic [TAG_W-1:0] cdb_tag(input logic [NUM_CDB*TAG_W-1:0] ser, input int j);
    return ser[(NUM_CDB-1-j)*TAG_W +: TAG_W];
  endfunction

  function automatic logic [DATA_W-1:0] cdb_data(input logic [NUM_CDB*DATA_W-1:0] ser, input int j);
    return ser[(NUM_CDB-1-j)*DATA_W +: DATA_W];
  endfunction

  // Highest-numbered matching bus wins since it is applied last.
  function automatic rs_opnd_t capture_opnd(input rs_opnd_t o,
                                            input logic [NUM_CDB*TAG_W-1:0]  tags,
                                            input logic [NUM_CDB*DATA_W-1:0] data);
    rs_opnd_t n;
    n = o;
    for (int j = 0; j < NUM_CDB; j++) begin
      if (!o.r && tag_match(o.q, cdb_tag(tags, j))) begin
        n.v = cdb_data(data, j);
        n.r = 1'b1;
      end
    end
    return n;
  endfunction

  // Same-edge forwarding: a tag operand is resolved against the live CDB.
  function automatic rs_opnd_t dispatch_opnd(input logic [DATA_W-1:0] val, input logic dtype,
                                             input logic [NUM_CDB*TAG_W-1:0]  tags,
                                             input logic [NUM_CDB*DATA_W-1:0] data);
    rs_opnd_t o;
    o = '0;
    if (!dtype) begin
      o.v = val;
      o.r = 1'b1;
    end else begin
      o.q = val[TAG_W-1:0];
    end
    return capture_opnd(o, tags, data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reservation_station_if.sv
`default_nettype none
// ------------------------------------------------------------------
// reservation_station_if: dispatch, CDB and issue bundle of the RS
// Revision: 1.0
// ------------------------------------------------------------------
interface reservation_station_if #(parameter int OP_W = 4);
  import rs_pkg::*;

  logic                             disp_valid_A, disp_valid_B;
  logic [OP_W-1:0]                  disp_op_A, disp_op_B;
  logic [DATA_W-1:0]                disp_v1_A, disp_v2_A, disp_v1_B, disp_v2_B;
  logic                             disp_t1_A, disp_t2_A, disp_t1_B, disp_t2_B;
  logic                             disp_ready_A, disp_ready_B;
  logic [TAG_W-1:0]                 alloc_tag_A, alloc_tag_B;
  logic [NUM_CDB*DATA_W-1:0]        CDB_data_serialized;
  logic [NUM_CDB*TAG_W-1:0]         CDB_tag_serialized;
  logic                             iss_valid, iss_ready;
  logic [OP_W-1:0]                  iss_op;
  logic [DATA_W-1:0]                iss_a, iss_b;
  logic [TAG_W-1:0]                 iss_tag;

  modport master (
    output disp_valid_A, disp_op_A, disp_v1_A, disp_v2_A, disp_t1_A, disp_t2_A,
    output disp_valid_B, disp_op_B, disp_v1_B, disp_v2_B, disp_t1_B, disp_t2_B,
    input  disp_ready_A, disp_ready_B, alloc_tag_A, alloc_tag_B,
    output CDB_data_serialized, CDB_tag_serialized,
    input  iss_valid, iss_op, iss_a, iss_b, iss_tag,
    output iss_ready
  );

  modport slave (
    input  disp_valid_A, disp_op_A, disp_v1_A, disp_v2_A, disp_t1_A, disp_t2_A,
    input  disp_valid_B, disp_op_B, disp_v1_B, disp_v2_B, disp_t1_B, disp_t2_B,
    output disp_ready_A, disp_ready_B, alloc_tag_A, alloc_tag_B,
    input  CDB_data_serialized, CDB_tag_serialized,
    output iss_valid, iss_op, iss_a, iss_b, iss_tag,
    input  iss_ready
  );

endinterface
`default_nettype wire

// File: rtl/rs_prio_enc.sv
`default_nettype none
// ------------------------------------------------------------------
// rs_prio_enc: finds the lowest and second-lowest set bits of a vector
// Revision: 1.0
// ------------------------------------------------------------------
module rs_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  output logic             o_first_valid,
  output logic [IDX_W-1:0] o_first_idx,
  output logic             o_second_valid,
  output logic [IDX_W-1:0] o_second_idx
);

  // Scanning downward, each hit demotes the previous (higher) hit to second.
  always_comb begin
    o_first_valid  = 1'b0;
    o_first_idx    = '0;
    o_second_valid = 1'b0;
    o_second_idx   = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_second_valid = o_first_valid;
        o_second_idx   = o_first_idx;
        o_first_valid  = 1'b1;
        o_first_idx    = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ------------------------------------------------------------------
// reservation_station: dual-dispatch Tomasulo RS with 3-bus CDB snoop
// Revision: 1.0
// ------------------------------------------------------------------
module reservation_station
  import rs_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int RS_ID   = 1,
  parameter int OP_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  reservation_station_if.slave  bus
);

  localparam int         c_idx_w = $clog2(ENTRIES);
  localparam logic [3:0] c_rs_id = 4'(RS_ID);

  rs_entry_t         r_entry [ENTRIES];
  logic [OP_W-1:0]   r_op    [ENTRIES];

  logic [ENTRIES-1:0] w_free, w_cand;
  logic               w_f0_valid, w_f1_valid, w_sel_valid, w_iss_unused_valid;
  logic [c_idx_w-1:0] w_f0_idx, w_f1_idx, w_sel_idx, w_iss_unused_idx, w_idx_b;
  logic               w_ready_a, w_ready_b, w_acc_a, w_acc_b, w_iss_valid, w_iss_fire;
  rs_entry_t          w_new_a, w_new_b;

  function automatic logic [TAG_W-1:0] entry_tag(input logic [c_idx_w-1:0] idx);
    return {c_rs_id, 4'(idx)};
  endfunction

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_vec
    assign w_free[gi] = ~r_entry[gi].busy;
    assign w_cand[gi] = r_entry[gi].busy & r_entry[gi].o1.r & r_entry[gi].o2.r;
  end

  rs_prio_enc #(.N(ENTRIES), .IDX_W(c_idx_w)) u_free_enc (
    .i_req          (w_free),
    .o_first_valid  (w_f0_valid),
    .o_first_idx    (w_f0_idx),
    .o_second_valid (w_f1_valid),
    .o_second_idx   (w_f1_idx)
  );

  rs_prio_enc #(.N(ENTRIES), .IDX_W(c_idx_w)) u_iss_enc (
    .i_req          (w_cand),
    .o_first_valid  (w_sel_valid),
    .o_first_idx    (w_sel_idx),
    .o_second_valid (w_iss_unused_valid),
    .o_second_idx   (w_iss_unused_idx)
  );

  // B slides to the second free slot only when A is also dispatching.
  assign w_idx_b   = bus.disp_valid_A ? w_f1_idx : w_f0_idx;
  assign w_ready_a = reset & en & w_f0_valid;
  assign w_ready_b = reset & en & (bus.disp_valid_A ? w_f1_valid : w_f0_valid);
  assign w_acc_a   = bus.disp_valid_A & w_ready_a;
  assign w_acc_b   = bus.disp_valid_B & w_ready_b;

  assign bus.disp_ready_A = w_ready_a;
  assign bus.disp_ready_B = w_ready_b;
  assign bus.alloc_tag_A  = entry_tag(w_f0_idx);
  assign bus.alloc_tag_B  = entry_tag(w_idx_b);

  always_comb begin
    w_new_a      = '0;
    w_new_a.busy = 1'b1;
    w_new_a.o1   = dispatch_opnd(bus.disp_v1_A, bus.disp_t1_A, bus.CDB_tag_serialized, bus.CDB_data_serialized);
    w_new_a.o2   = dispatch_opnd(bus.disp_v2_A, bus.disp_t2_A, bus.CDB_tag_serialized, bus.CDB_data_serialized);
    w_new_b      = '0;
    w_new_b.busy = 1'b1;
    w_new_b.o1   = dispatch_opnd(bus.disp_v1_B, bus.disp_t1_B, bus.CDB_tag_serialized, bus.CDB_data_serialized);
    w_new_b.o2   = dispatch_opnd(bus.disp_v2_B, bus.disp_t2_B, bus.CDB_tag_serialized, bus.CDB_data_serialized);
  end

  assign w_iss_valid = reset & en & w_sel_valid;
  assign w_iss_fire  = w_iss_valid & bus.iss_ready;

  assign bus.iss_valid = w_iss_valid;
  assign bus.iss_op    = w_iss_valid ? r_op[w_sel_idx]         : '0;
  assign bus.iss_a     = w_iss_valid ? r_entry[w_sel_idx].o1.v : '0;
  assign bus.iss_b     = w_iss_valid ? r_entry[w_sel_idx].o2.v : '0;
  assign bus.iss_tag   = w_iss_valid ? entry_tag(w_sel_idx)    : '0;

  // Dispatch only targets free slots, so it never collides with capture/issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_entry[i] <= '0;
        r_op[i]    <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (r_entry[i].busy) begin
          r_entry[i].o1 <= capture_opnd(r_entry[i].o1, bus.CDB_tag_serialized, bus.CDB_data_serialized);
          r_entry[i].o2 <= capture_opnd(r_entry[i].o2, bus.CDB_tag_serialized, bus.CDB_data_serialized);
          if (w_iss_fire && (w_sel_idx == c_idx_w'(i)))
            r_entry[i].busy <= 1'b0;
        end else if (w_acc_a && (w_f0_idx == c_idx_w'(i))) begin
          r_entry[i] <= w_new_a;
          r_op[i]    <= bus.disp_op_A;
        end else if (w_acc_b && (w_idx_b == c_idx_w'(i))) begin
          r_entry[i] <= w_new_b;
          r_op[i]    <= bus.disp_op_B;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_reservation_station: directed and randomized checks against a slot model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_reservation_station;

  localparam int ENTRIES = 4;
  localparam int RS_ID   = 1;

  logic clk = 1'b0;
  logic reset;
  logic en;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  reservation_station_if #(.OP_W(4)) rs_if ();

  reservation_station #(.ENTRIES(ENTRIES), .RS_ID(RS_ID), .OP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (rs_if)
  );

  // Reference model: one record per slot.
  bit          mb  [ENTRIES];
  logic [3:0]  mop [ENTRIES];
  logic [31:0] mv1 [ENTRIES];
  logic [31:0] mv2 [ENTRIES];
  logic [7:0]  mq1 [ENTRIES];
  logic [7:0]  mq2 [ENTRIES];
  bit          mr1 [ENTRIES];
  bit          mr2 [ENTRIES];
  logic [7:0]  ct  [3];
  logic [31:0] cd  [3];

  function automatic logic [7:0] tag_of(input int i);
    return 8'((RS_ID << 4) + i);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) mb[i] = 1'b0;
  endtask

  task automatic drive_cdb();
    rs_if.CDB_tag_serialized  = {ct[0], ct[1], ct[2]};
    rs_if.CDB_data_serialized = {cd[0], cd[1], cd[2]};
  endtask

  task automatic idle();
    rs_if.disp_valid_A = 0; rs_if.disp_op_A = 0; rs_if.disp_v1_A = 0; rs_if.disp_v2_A = 0;
    rs_if.disp_t1_A = 0; rs_if.disp_t2_A = 0;
    rs_if.disp_valid_B = 0; rs_if.disp_op_B = 0; rs_if.disp_v1_B = 0; rs_if.disp_v2_B = 0;
    rs_if.disp_t1_B = 0; rs_if.disp_t2_B = 0;
    for (int j = 0; j < 3; j++) begin ct[j] = 0; cd[j] = 0; end
    drive_cdb();
  endtask

  task automatic set_a(input logic [3:0] op, input logic [31:0] v1, input logic t1,
                       input logic [31:0] v2, input logic t2);
    rs_if.disp_valid_A = 1; rs_if.disp_op_A = op;
    rs_if.disp_v1_A = v1; rs_if.disp_t1_A = t1; rs_if.disp_v2_A = v2; rs_if.disp_t2_A = t2;
  endtask

  task automatic set_b(input logic [3:0] op, input logic [31:0] v1, input logic t1,
                       input logic [31:0] v2, input logic t2);
    rs_if.disp_valid_B = 1; rs_if.disp_op_B = op;
    rs_if.disp_v1_B = v1; rs_if.disp_t1_B = t1; rs_if.disp_v2_B = v2; rs_if.disp_t2_B = t2;
  endtask

  // Operand as captured at dispatch, including same-edge CDB forwarding.
  task automatic model_opnd(input logic [31:0] val, input logic t,
                            output logic [31:0] v, output logic [7:0] q, output bit r);
    v = val; q = val[7:0]; r = !t;
    if (t)
      for (int j = 0; j < 3; j++)
        if (ct[j] != 0 && ct[j] == q) begin v = cd[j]; r = 1; end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    int nfree, f0, f1, fb, sel;
    bit era, erb, eiv;
    @(negedge clk);
    nfree = 0; f0 = -1; f1 = -1; sel = -1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!mb[i]) begin
        if (f0 < 0) f0 = i; else if (f1 < 0) f1 = i;
        nfree++;
      end else if (mr1[i] && mr2[i] && sel < 0) sel = i;
    end
    fb  = rs_if.disp_valid_A ? f1 : f0;
    era = en && nfree >= 1;
    erb = en && (rs_if.disp_valid_A ? nfree >= 2 : nfree >= 1);
    eiv = en && sel >= 0;

    n_chk++;
    if (rs_if.disp_ready_A !== era) begin
      n_err++; $display("FAIL disp_ready_A @%0t: got %b want %b", $time, rs_if.disp_ready_A, era);
    end
    if (era) begin
      n_chk++;
      if (rs_if.alloc_tag_A !== tag_of(f0)) begin
        n_err++; $display("FAIL alloc_tag_A @%0t: got %h want %h", $time, rs_if.alloc_tag_A, tag_of(f0));
      end
    end
    n_chk++;
    if (rs_if.disp_ready_B !== erb) begin
      n_err++; $display("FAIL disp_ready_B @%0t: got %b want %b", $time, rs_if.disp_ready_B, erb);
    end
    if (erb) begin
      n_chk++;
      if (rs_if.alloc_tag_B !== tag_of(fb)) begin
        n_err++; $display("FAIL alloc_tag_B @%0t: got %h want %h", $time, rs_if.alloc_tag_B, tag_of(fb));
      end
    end
    n_chk++;
    if (rs_if.iss_valid !== eiv) begin
      n_err++; $display("FAIL iss_valid @%0t: got %b want %b", $time, rs_if.iss_valid, eiv);
    end
    if (eiv) begin
      n_chk++;
      if ({rs_if.iss_op, rs_if.iss_a, rs_if.iss_b, rs_if.iss_tag} !== {mop[sel], mv1[sel], mv2[sel], tag_of(sel)}) begin
        n_err++;
        $display("FAIL iss_payload @%0t: got op=%h a=%h b=%h tag=%h want op=%h a=%h b=%h tag=%h", $time,
                 rs_if.iss_op, rs_if.iss_a, rs_if.iss_b, rs_if.iss_tag, mop[sel], mv1[sel], mv2[sel], tag_of(sel));
      end
    end

    if (en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (mb[i]) begin
          for (int j = 0; j < 3; j++) begin
            if (!mr1[i] && ct[j] != 0 && ct[j] == mq1[i]) begin mv1[i] = cd[j]; mr1[i] = 1; end
            if (!mr2[i] && ct[j] != 0 && ct[j] == mq2[i]) begin mv2[i] = cd[j]; mr2[i] = 1; end
          end
        end
      end
      if (eiv && rs_if.iss_ready) mb[sel] = 0;
      if (rs_if.disp_valid_A && era) begin
        mb[f0] = 1; mop[f0] = rs_if.disp_op_A;
        model_opnd(rs_if.disp_v1_A, rs_if.disp_t1_A, mv1[f0], mq1[f0], mr1[f0]);
        model_opnd(rs_if.disp_v2_A, rs_if.disp_t2_A, mv2[f0], mq2[f0], mr2[f0]);
      end
      if (rs_if.disp_valid_B && erb) begin
        mb[fb] = 1; mop[fb] = rs_if.disp_op_B;
        model_opnd(rs_if.disp_v1_B, rs_if.disp_t1_B, mv1[fb], mq1[fb], mr1[fb]);
        model_opnd(rs_if.disp_v2_B, rs_if.disp_t2_B, mv2[fb], mq2[fb], mr2[fb]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; en = 1; rs_if.iss_ready = 0; idle(); model_clear();
    @(negedge clk);
    n_chk++;
    if ({rs_if.disp_ready_A, rs_if.disp_ready_B, rs_if.iss_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {rs_if.disp_ready_A, rs_if.disp_ready_B, rs_if.iss_valid});
    end
    n_chk++;
    if ({rs_if.iss_op, rs_if.iss_a, rs_if.iss_b, rs_if.iss_tag} !== '0) begin
      n_err++; $display("FAIL reset_iss: got a=%h tag=%h want 0", rs_if.iss_a, rs_if.iss_tag);
    end
    @(posedge clk); #1;
    reset = 1;
    step();
  endtask

  task automatic test_basic_issue();
    set_a(4'd3, 32'd5, 0, 32'd7, 0);
    #1;
    n_chk++;
    if (rs_if.alloc_tag_A !== 8'h10) begin
      n_err++; $display("FAIL basic_alloc_tag: got %h want 10", rs_if.alloc_tag_A);
    end
    step();
    idle();
    #1;
    n_chk++;
    if ({rs_if.iss_valid, rs_if.iss_a, rs_if.iss_b, rs_if.iss_tag} !== {1'b1, 32'd5, 32'd7, 8'h10}) begin
      n_err++; $display("FAIL basic_issue: got v=%b a=%h b=%h tag=%h want 1/5/7/10",
                        rs_if.iss_valid, rs_if.iss_a, rs_if.iss_b, rs_if.iss_tag);
    end
    rs_if.iss_ready = 1;
    step();
    rs_if.iss_ready = 0;
    step();
  endtask

  task automatic test_cdb_capture();
    set_a(4'd1, 32'h21, 1, 32'd9, 0);
    step();
    idle();
    rs_if.iss_ready = 1;
    #1;
    n_chk++;
    if (rs_if.iss_valid !== 1'b0) begin
      n_err++; $display("FAIL cdb_pending: got iss_valid=%b want 0", rs_if.iss_valid);
    end
    ct[1] = 8'h21; cd[1] = 32'hDEAD; drive_cdb();
    step();
    idle();
    #1;
    n_chk++;
    if ({rs_if.iss_valid, rs_if.iss_a, rs_if.iss_b} !== {1'b1, 32'hDEAD, 32'd9}) begin
      n_err++; $display("FAIL cdb_capture: got v=%b a=%h b=%h want 1/DEAD/9", rs_if.iss_valid, rs_if.iss_a, rs_if.iss_b);
    end
    step();
    rs_if.iss_ready = 0;
  endtask

  task automatic test_dispatch_forward();
    set_a(4'd2, 32'h22, 1, 32'd1, 0);
    ct[2] = 8'h22; cd[2] = 32'h1234; drive_cdb();
    step();
    idle();
    #1;
    n_chk++;
    if ({rs_if.iss_valid, rs_if.iss_a} !== {1'b1, 32'h1234}) begin
      n_err++; $display("FAIL forward: got v=%b a=%h want 1/1234", rs_if.iss_valid, rs_if.iss_a);
    end
    rs_if.iss_ready = 1;
    step();
    rs_if.iss_ready = 0;
  endtask

  task automatic test_dual_dispatch();
    set_a(4'd4, 32'h2F, 1, 32'd0, 0); set_b(4'd5, 32'h2F, 1, 32'd1, 0);
    step();
    idle(); set_a(4'd6, 32'h2F, 1, 32'd2, 0);
    step();
    set_a(4'd7, 32'h2F, 1, 32'd3, 0); set_b(4'd8, 32'h2F, 1, 32'd4, 0);
    #1;
    n_chk++;
    if ({rs_if.disp_ready_A, rs_if.disp_ready_B, rs_if.alloc_tag_A} !== {2'b10, 8'h13}) begin
      n_err++; $display("FAIL dual_one_free: got rA=%b rB=%b tagA=%h want 1/0/13",
                        rs_if.disp_ready_A, rs_if.disp_ready_B, rs_if.alloc_tag_A);
    end
    step();
    idle(); ct[0] = 8'h2F; cd[0] = 32'hCAFE; drive_cdb();
    step();
    idle(); rs_if.iss_ready = 1;
    repeat (4) step();
    rs_if.iss_ready = 0;
    set_a(4'd9, 32'h2F, 1, 32'd5, 0); set_b(4'd10, 32'h2F, 1, 32'd6, 0);
    step();
    idle(); set_a(4'd11, 32'h2F, 1, 32'd7, 0);
    step();
    idle(); set_b(4'd12, 32'h2F, 1, 32'd8, 0);
    #1;
    n_chk++;
    if ({rs_if.disp_ready_B, rs_if.alloc_tag_B} !== {1'b1, 8'h13}) begin
      n_err++; $display("FAIL b_alone: got rB=%b tagB=%h want 1/13", rs_if.disp_ready_B, rs_if.alloc_tag_B);
    end
    step();
  endtask

  task automatic test_full();
    idle();
    set_a(4'd13, 32'd1, 0, 32'd2, 0); set_b(4'd14, 32'd3, 0, 32'd4, 0);
    #1;
    n_chk++;
    if ({rs_if.disp_ready_A, rs_if.disp_ready_B} !== 2'b00) begin
      n_err++; $display("FAIL full_ready: got %b want 00", {rs_if.disp_ready_A, rs_if.disp_ready_B});
    end
    ct[2] = 8'h2F; cd[2] = 32'hBEEF; drive_cdb();
    step();
    ct[2] = 0; cd[2] = 0; drive_cdb();
    repeat (3) step();
    n_chk++;
    if ({rs_if.iss_valid, rs_if.iss_tag, rs_if.iss_a} !== {1'b1, 8'h10, 32'hBEEF}) begin
      n_err++; $display("FAIL full_hold: got v=%b tag=%h a=%h want 1/10/BEEF", rs_if.iss_valid, rs_if.iss_tag, rs_if.iss_a);
    end
    rs_if.iss_ready = 1;
    step();
    rs_if.iss_ready = 0;
    #1;
    n_chk++;
    if ({rs_if.disp_ready_A, rs_if.alloc_tag_A} !== {1'b1, 8'h10}) begin
      n_err++; $display("FAIL full_free: got rA=%b tagA=%h want 1/10", rs_if.disp_ready_A, rs_if.alloc_tag_A);
    end
    idle(); rs_if.iss_ready = 1;
    repeat (4) step();
    rs_if.iss_ready = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      en = ($urandom % 8) != 0;
      rs_if.iss_ready = $urandom % 2;
      if ($urandom % 2) begin
        logic t1, t2;
        t1 = $urandom % 2; t2 = $urandom % 2;
        set_a(4'($urandom), t1 ? 32'(8'h20 + $urandom % 8) : $urandom, t1,
                            t2 ? 32'(8'h20 + $urandom % 8) : $urandom, t2);
      end
      if ($urandom % 2) begin
        logic t1, t2;
        t1 = $urandom % 2; t2 = $urandom % 2;
        set_b(4'($urandom), t1 ? 32'(8'h20 + $urandom % 8) : $urandom, t1,
                            t2 ? 32'(8'h20 + $urandom % 8) : $urandom, t2);
      end
      for (int j = 0; j < 3; j++) begin
        ct[j] = ($urandom % 2) ? 8'(8'h20 + $urandom % 8) : 8'h00;
        cd[j] = $urandom;
        for (int k = 0; k < j; k++)
          if (ct[j] == ct[k]) ct[j] = 8'h00;
      end
      drive_cdb();
      step();
    end
    en = 1; idle(); rs_if.iss_ready = 0;
  endtask

  task automatic test_reset_midrun();
    set_a(4'd1, 32'd11, 0, 32'd12, 0); set_b(4'd2, 32'd13, 0, 32'd14, 0);
    step();
    idle(); set_a(4'd3, 32'h25, 1, 32'd15, 0);
    step();
    idle();
    #1;
    n_chk++;
    if (rs_if.iss_valid !== 1'b1) begin
      n_err++; $display("FAIL midrun_pre: got iss_valid=%b want 1", rs_if.iss_valid);
    end
    @(negedge clk); #1;
    reset = 0;
    #1;
    n_chk++;
    if ({rs_if.iss_valid, rs_if.disp_ready_A, rs_if.iss_a} !== {2'b00, 32'd0}) begin
      n_err++; $display("FAIL midrun_async: got v=%b rA=%b a=%h want 0/0/0", rs_if.iss_valid, rs_if.disp_ready_A, rs_if.iss_a);
    end
    model_clear();
    @(posedge clk); #1;
    reset = 1;
    #1;
    n_chk++;
    if ({rs_if.iss_valid, rs_if.disp_ready_A, rs_if.alloc_tag_A} !== {2'b01, 8'h10}) begin
      n_err++; $display("FAIL midrun_after: got v=%b rA=%b tagA=%h want 0/1/10", rs_if.iss_valid, rs_if.disp_ready_A, rs_if.alloc_tag_A);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_cdb_capture();
    test_dispatch_forward();
    test_dual_dispatch();
    test_full();
    test_random();
    test_reset();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
